// File: rtl/phone_pattern_detector_if.sv
// Character bus between the upstream classifier, the phone pattern detector and the capture logic.
// The end-of-stream strobe eos is present only when PPD_EOS_FLUSH_EN is defined.
interface phone_pattern_detector_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              en;
  logic [DATA_W-1:0] data_in;
  logic              is_number_in;
  logic              is_white_in;
  logic              mode;
  logic              clear_cnt;
`ifdef PPD_EOS_FLUSH_EN
  logic              eos;
`endif
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              match_short;
  logic              match_long;
  logic [CNT_W-1:0]  match_cnt;
  logic              busy;

`ifdef PPD_EOS_FLUSH_EN
  modport master (
    output en, data_in, is_number_in, is_white_in, mode, clear_cnt, eos,
    input  data_out, data_valid, match_short, match_long, match_cnt, busy
  );
  modport slave (
    input  en, data_in, is_number_in, is_white_in, mode, clear_cnt, eos,
    output data_out, data_valid, match_short, match_long, match_cnt, busy
  );
`else
  modport master (
    output en, data_in, is_number_in, is_white_in, mode, clear_cnt,
    input  data_out, data_valid, match_short, match_long, match_cnt, busy
  );
  modport slave (
    input  en, data_in, is_number_in, is_white_in, mode, clear_cnt,
    output data_out, data_valid, match_short, match_long, match_cnt, busy
  );
`endif
endinterface

// File: rtl/phone_pattern_detector.sv
// Run-length FSM detecting GROUP_CNT groups of GROUP_LEN digits bounded by non-digits, with a match counter.
// Optional feature macro PPD_EOS_FLUSH_EN adds an end-of-stream flush that terminates a pending match.
module phone_pattern_detector #(
  parameter int GROUP_LEN = 3,
  parameter int GROUP_CNT = 3,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16
) (
  input logic                     clk,
  input logic                     rst,
  phone_pattern_detector_if.slave bus
);
  localparam int TOTAL  = GROUP_LEN * GROUP_CNT;
  localparam int DCNT_W = $clog2(TOTAL + 1);
  localparam int GCNT_W = $clog2(GROUP_CNT + 1);
  localparam logic [DCNT_W-1:0] TOTAL_C = DCNT_W'(TOTAL);
  localparam logic [DCNT_W-1:0] GLEN_C  = DCNT_W'(GROUP_LEN);
  localparam logic [DCNT_W-1:0] DONE_C  = DCNT_W'(1);
  localparam logic [GCNT_W-1:0] GLAST_C = GCNT_W'(GROUP_CNT - 1);
  localparam logic [GCNT_W-1:0] GONE_C  = GCNT_W'(1);

  typedef enum logic [2:0] {BND, DIG, SEP, TAIL, REJ} state_e;

  state_e            state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d, dinc;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              short_q, short_d;
  logic              long_q, long_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flush, digit, white, match;

`ifdef PPD_EOS_FLUSH_EN
  assign flush = bus.eos;
`else
  assign flush = 1'b0;
`endif

  assign digit = bus.is_number_in;
  assign white = bus.is_white_in & ~bus.is_number_in;
  assign dinc  = dcnt_q + DONE_C;
  assign match = short_d | long_d;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    gcnt_d  = gcnt_q;
    mode_d  = mode_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    if (flush) begin
      state_d = BND;
      short_d = (state_q == TAIL) & ~mode_q;
      long_d  = (state_q == TAIL) & mode_q;
    end else if (bus.en) begin
      if (state_q == BND) mode_d = bus.mode;
      unique case (state_q)
        BND: begin
          if (digit) begin
            dcnt_d  = DONE_C;
            gcnt_d  = '0;
            state_d = (TOTAL == 1) ? TAIL : DIG;
          end
        end
        DIG: begin
          if (!mode_q) begin
            if (digit) begin
              dcnt_d = dinc;
              if (dinc == TOTAL_C) state_d = TAIL;
            end else begin
              state_d = BND;
            end
          end else if (digit) begin
            // a digit beyond a full group that cannot end the pattern makes the run unusable
            if (dcnt_q < GLEN_C) begin
              dcnt_d = dinc;
              if (dinc == GLEN_C && gcnt_q == GLAST_C) state_d = TAIL;
            end else begin
              state_d = REJ;
            end
          end else if (white && dcnt_q == GLEN_C && gcnt_q < GLAST_C) begin
            state_d = SEP;
            gcnt_d  = gcnt_q + GONE_C;
          end else begin
            state_d = BND;
          end
        end
        SEP: begin
          if (digit) begin
            dcnt_d  = DONE_C;
            state_d = (GROUP_LEN == 1 && gcnt_q == GLAST_C) ? TAIL : DIG;
          end else begin
            state_d = BND;
          end
        end
        TAIL: begin
          if (digit) begin
            state_d = REJ;
          end else begin
            state_d = BND;
            short_d = ~mode_q;
            long_d  = mode_q;
          end
        end
        REJ: begin
          if (!digit) state_d = BND;
        end
        default: state_d = BND;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.clear_cnt) cnt_d = CNT_W'(match);
    else if (match && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BND;
      dcnt_q  <= '0;
      gcnt_q  <= '0;
      mode_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      gcnt_q  <= gcnt_d;
      mode_q  <= mode_d;
      valid_q <= bus.en | flush;
      short_q <= short_d;
      long_q  <= long_d;
      cnt_q   <= cnt_d;
      if (bus.en | flush) data_q <= bus.data_in;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.match_short = short_q;
  assign bus.match_long  = long_q;
  assign bus.match_cnt   = cnt_q;
  assign bus.busy        = (state_q != BND);
endmodule
